// File: rtl/jtpang_ba_resp_pkg.sv
// Shared definitions for the 4-bank SDRAM read responder: bus widths,
// FSM encodings and the per-word tag carried alongside the memory pipeline.
package jtpang_ba_resp_pkg;

  localparam int BANKS = 4;
  localparam int AW    = 22;
  localparam int DW    = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  function automatic logic [1:0] ptr_next(input logic [1:0] gnt);
    return gnt + 2'd1;
  endfunction

endpackage

// File: rtl/jtpang_ba_rrarb.sv
// Combinational 4-way round-robin arbiter: picks the first requesting bank
// at or after the pointer, wrapping modulo 4.
module jtpang_ba_rrarb
  import jtpang_ba_resp_pkg::*;
(
  input  logic [BANKS-1:0] i_req,
  input  logic [1:0]       i_ptr,
  output logic             o_gnt_valid,
  output logic [1:0]       o_gnt
);

  logic [1:0] w_idx;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt       = i_ptr;
    w_idx       = i_ptr;
    // Walk from farthest to nearest so the bank closest to the pointer wins.
    for (int k = BANKS - 1; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_req[w_idx]) begin
        o_gnt_valid = 1'b1;
        o_gnt       = w_idx;
      end
    end
  end

endmodule

// File: rtl/jtpang_ba_resp.sv
// Read-only responder for the jtframe 4-bank SDRAM request interface:
// round-robin grant, BURST-word fetch from a LAT-cycle pipelined memory port.
module jtpang_ba_resp
  import jtpang_ba_resp_pkg::*;
#(
  parameter int BURST = 2,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ba0_addr,
  input  logic [AW-1:0]    ba1_addr,
  input  logic [AW-1:0]    ba2_addr,
  input  logic [AW-1:0]    ba3_addr,
  input  logic [BANKS-1:0] ba_rd,
  output logic [BANKS-1:0] ba_ack,
  output logic [BANKS-1:0] ba_dst,
  output logic [BANKS-1:0] ba_dok,
  output logic [BANKS-1:0] ba_rdy,
  output logic [DW-1:0]    data_read,
  output logic [AW+1:0]    mem_addr,
  output logic             mem_rd,
  input  logic [DW-1:0]    mem_dout
);

  localparam logic [2:0] LAST_IDX = 3'(BURST - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_bank;
  logic [AW-1:0]    r_addr;
  logic [2:0]       r_cnt;
  logic [BANKS-1:0] r_ack;
  logic             r_mem_rd;
  logic [AW+1:0]    r_mem_addr;
  tag_t [LAT-1:0]   r_pipe;
  logic [BANKS-1:0] r_dst;
  logic [BANKS-1:0] r_dok;
  logic [BANKS-1:0] r_rdy;
  logic [DW-1:0]    r_data;

  logic             w_gnt_valid;
  logic [1:0]       w_gnt;
  logic [AW-1:0]    w_gnt_addr;
  tag_t             w_tag_in;

  jtpang_ba_rrarb u_arb (
    .i_req       (ba_rd),
    .i_ptr       (r_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt       (w_gnt)
  );

  always_comb begin
    case (w_gnt)
      2'd0:    w_gnt_addr = ba0_addr;
      2'd1:    w_gnt_addr = ba1_addr;
      2'd2:    w_gnt_addr = ba2_addr;
      default: w_gnt_addr = ba3_addr;
    endcase
  end

  // Tag for the word whose mem_rd is being launched at this edge.
  always_comb begin
    w_tag_in = '0;
    if (r_state == ST_IDLE && w_gnt_valid) begin
      w_tag_in.valid = 1'b1;
      w_tag_in.first = 1'b1;
      w_tag_in.last  = (BURST == 1);
    end else if (r_state == ST_ISSUE) begin
      w_tag_in.valid = 1'b1;
      w_tag_in.last  = (r_cnt == LAST_IDX);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'd0;
      r_bank     <= 2'd0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_ack    <= '0;
      r_mem_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_ack[w_gnt] <= 1'b1;
            r_bank       <= w_gnt;
            r_ptr        <= ptr_next(w_gnt);
            r_mem_rd     <= 1'b1;
            r_mem_addr   <= {w_gnt, w_gnt_addr};
            r_addr       <= w_gnt_addr + AW'(1);
            r_cnt        <= 3'd1;
            r_state      <= (BURST == 1) ? ST_WAIT : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Word address wraps inside the bank; the bank bits come from r_bank.
          r_mem_rd   <= 1'b1;
          r_mem_addr <= {r_bank, r_addr};
          r_addr     <= r_addr + AW'(1);
          r_cnt      <= r_cnt + 3'd1;
          if (r_cnt == LAST_IDX) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (|r_rdy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the tag pipe is reset (not just the FSM) so an aborted burst leaves no stray dok/rdy behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pipe <= '0;
      r_dst  <= '0;
      r_dok  <= '0;
      r_rdy  <= '0;
      r_data <= '0;
    end else begin
      r_pipe[0] <= w_tag_in;
      for (int k = 1; k < LAT; k++) r_pipe[k] <= r_pipe[k-1];
      r_dst <= '0;
      r_dok <= '0;
      r_rdy <= '0;
      if (r_pipe[LAT-1].valid) begin
        r_data         <= mem_dout;
        r_dok[r_bank]  <= 1'b1;
        r_dst[r_bank]  <= r_pipe[LAT-1].first;
        r_rdy[r_bank]  <= r_pipe[LAT-1].last;
      end
    end
  end

  assign ba_ack    = r_ack;
  assign ba_dst    = r_dst;
  assign ba_dok    = r_dok;
  assign ba_rdy    = r_rdy;
  assign data_read = r_data;
  assign mem_addr  = r_mem_addr;
  assign mem_rd    = r_mem_rd;

endmodule

// File: tb/tb_jtpang_ba_resp.sv
// Bench for jtpang_ba_resp: table-driven single requests plus hand sequences,
// with a scoreboard of expected acks, memory addresses and data words.
module tb_jtpang_ba_resp;

  localparam int BURST   = 2;
  localparam int LAT     = 2;
  localparam int ACK_LAT = 1;
  localparam int DST_LAT = 1 + LAT;
  localparam int RDY_LAT = LAT + BURST;

  typedef struct {
    logic [1:0]  bank;
    logic [15:0] data;
    logic        first;
    logic        last;
  } word_t;

  typedef struct {
    logic [1:0]  bank;
    logic [21:0] addr;
    logic [23:0] exp_a0;
    logic [23:0] exp_a1;
    logic [15:0] exp_d0;
    logic [15:0] exp_d1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] a0, a1, a2, a3;
  logic [3:0]  rd;
  logic [3:0]  ack, dst, dok, rdy;
  logic [15:0] dr;
  logic [23:0] maddr;
  logic        mrd;
  logic [15:0] mdout;

  logic [21:0] a3_1;
  logic [3:0]  rd1;
  logic [3:0]  ack1, dst1, dok1, rdy1;
  logic [15:0] dr1;
  logic [23:0] maddr1;
  logic        mrd1;
  logic [15:0] mdout1;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  word_t       exp_q[$];
  logic [1:0]  ack_q[$];
  logic [23:0] addr_q[$];
  logic [3:0]  busy;
  logic [15:0] model_dr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] + {a[23:22], 14'd0};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction

  // Memory for the main DUT: one register stage, so data is captured LAT=2 edges after mem_rd launch.
  always @(posedge clk) mdout <= mrd ? mem_word(maddr) : 16'hDEAD;
  // Memory for the LAT=1 DUT: asynchronous read.
  assign mdout1 = mrd1 ? mem_word(maddr1) : 16'hDEAD;

  jtpang_ba_resp #(.BURST(BURST), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(a0), .ba1_addr(a1), .ba2_addr(a2), .ba3_addr(a3),
    .ba_rd(rd), .ba_ack(ack), .ba_dst(dst), .ba_dok(dok), .ba_rdy(rdy),
    .data_read(dr), .mem_addr(maddr), .mem_rd(mrd), .mem_dout(mdout)
  );

  jtpang_ba_resp #(.BURST(1), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(22'd0), .ba1_addr(22'd0), .ba2_addr(22'd0), .ba3_addr(a3_1),
    .ba_rd(rd1), .ba_ack(ack1), .ba_dst(dst1), .ba_dok(dok1), .ba_rdy(rdy1),
    .data_read(dr1), .mem_addr(maddr1), .mem_rd(mrd1), .mem_dout(mdout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    logic [1:0] b;
    word_t      w;
    if (!rst_n) begin
      exp_q.delete();
      ack_q.delete();
      addr_q.delete();
      busy     = '0;
      model_dr = '0;
    end else begin
      if (|ack) begin
        if (ack_q.size() == 0) check("unexpected_ack", 32'(ack), 32'd0);
        else begin
          b = ack_q.pop_front();
          check("ack_bank", 32'(ack), 32'(onehot(b)));
        end
        for (int i = 0; i < 4; i++)
          if (ack[i]) begin
            check("reack_before_rdy", 32'(busy[i]), 32'd0);
            busy[i] = 1'b1;
          end
      end
      if (|dok) begin
        if (exp_q.size() == 0) check("unexpected_dok", 32'(dok), 32'd0);
        else begin
          w = exp_q.pop_front();
          model_dr = w.data;
          check("dok_bank", 32'(dok), 32'(onehot(w.bank)));
          check("data", 32'(dr), 32'(w.data));
          check("dst", 32'(dst), w.first ? 32'(onehot(w.bank)) : 32'd0);
          check("rdy", 32'(rdy), w.last ? 32'(onehot(w.bank)) : 32'd0);
        end
      end else begin
        check("strobe_without_dok", {24'd0, dst, rdy}, 32'd0);
        check("data_hold", 32'(dr), 32'(model_dr));
      end
      busy = busy & ~rdy;
      if (mrd) begin
        if (addr_q.size() == 0) check("unexpected_mem_rd", 32'(maddr), 32'hFFFFFFFF);
        else check("mem_addr", 32'(maddr), 32'(addr_q.pop_front()));
      end
    end
  end

  task automatic set_addr(input logic [1:0] b, input logic [21:0] a);
    case (b)
      2'd0: a0 = a;
      2'd1: a1 = a;
      2'd2: a2 = a;
      default: a3 = a;
    endcase
  endtask

  task automatic push_burst(input logic [1:0] b, input logic [21:0] a);
    logic [23:0] ma;
    word_t w;
    ack_q.push_back(b);
    for (int i = 0; i < BURST; i++) begin
      ma = {b, a + 22'(i)};
      addr_q.push_back(ma);
      w.bank  = b;
      w.data  = mem_word(ma);
      w.first = (i == 0);
      w.last  = (i == BURST - 1);
      exp_q.push_back(w);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int req_c, ack_c, dst_c, rdy_c;
    word_t w;
    ack_q.push_back(v.bank);
    w.bank = v.bank; w.data = v.exp_d0; w.first = 1'b1; w.last = 1'b0;
    exp_q.push_back(w);
    w.data = v.exp_d1; w.first = 1'b0; w.last = 1'b1;
    exp_q.push_back(w);
    addr_q.push_back(v.exp_a0);
    addr_q.push_back(v.exp_a1);
    set_addr(v.bank, v.addr);
    rd[v.bank] = 1'b1;
    req_c = cyc;
    ack_c = -1; dst_c = -1; rdy_c = -1;
    for (int k = 0; k < 30 && rdy_c < 0; k++) begin
      @(negedge clk);
      if (ack[v.bank] && ack_c < 0) begin
        ack_c = cyc - req_c;
        rd[v.bank] = 1'b0;
      end
      if (dst[v.bank] && dst_c < 0) dst_c = cyc - req_c;
      if (rdy[v.bank] && rdy_c < 0) rdy_c = cyc - req_c;
    end
    rd[v.bank] = 1'b0;
    check("ack_latency", 32'(ack_c), 32'(ACK_LAT));
    check("dst_latency", 32'(dst_c), 32'(DST_LAT));
    check("rdy_latency", 32'(rdy_c), 32'(RDY_LAT));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_queues_empty(input string tag);
    check({tag, "_exp_q_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ack_q_left"}, 32'(ack_q.size()), 32'd0);
    check({tag, "_addr_q_left"}, 32'(addr_q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   n_rdy, n_stray, n_ack1;
    bit   seen;

    vecs[0] = '{2'd0, 22'h000100, 24'h000100, 24'h000101, 16'h0100, 16'h0101};
    vecs[1] = '{2'd1, 22'h12345A, 24'h52345A, 24'h52345B, 16'h745A, 16'h745B};
    vecs[2] = '{2'd2, 22'h3FFFFF, 24'hBFFFFF, 24'h800000, 16'h7FFF, 16'h8000};
    vecs[3] = '{2'd3, 22'h00FFFF, 24'hC0FFFF, 24'hC10000, 16'hBFFF, 16'hC000};
    vecs[4] = '{2'd0, 22'h3FFFFE, 24'h3FFFFE, 24'h3FFFFF, 16'hFFFE, 16'hFFFF};

    rst_n = 1'b0;
    rd = '0; rd1 = '0;
    a0 = '0; a1 = '0; a2 = '0; a3 = '0; a3_1 = '0;
    repeat (3) @(negedge clk);

    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dst", 32'(dst), 32'd0);
    check("rst_dok", 32'(dok), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_data", 32'(dr), 32'd0);
    check("rst_mem_rd", 32'(mrd), 32'd0);
    check("rst_mem_addr", 32'(maddr), 32'd0);
    check("rst1_dok", 32'(dok1), 32'd0);
    check("rst1_mem_rd", 32'(mrd1), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single requests, including bank-local address wrap; each drops ba_rd on its ack cycle.
    foreach (vecs[i]) run_vec(vecs[i]);
    check_queues_empty("table");

    // All four banks requesting continuously from a fresh pointer.
    reset_pulse();
    a0 = 22'h000010; a1 = 22'h000020; a2 = 22'h000030; a3 = 22'h000040;
    push_burst(2'd0, a0);
    push_burst(2'd1, a1);
    push_burst(2'd2, a2);
    push_burst(2'd3, a3);
    push_burst(2'd0, a0);
    rd = 4'b1111;
    n_rdy = 0;
    for (int k = 0; k < 100 && n_rdy < 5; k++) begin
      @(negedge clk);
      if (|rdy) n_rdy++;
      if (n_rdy == 5) rd = 4'b0000;
    end
    rd = 4'b0000;
    check("all_banks_rdy_count", 32'(n_rdy), 32'd5);
    repeat (6) @(negedge clk);
    check_queues_empty("all_banks");

    // Bank1 request raised and withdrawn while bank0 is in flight: never acked.
    a0 = 22'h000200; a1 = 22'h000777;
    push_burst(2'd0, a0);
    rd[0] = 1'b1;
    seen = 1'b0;
    n_ack1 = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ack[0]) seen = 1'b1;
    end
    check("withdraw_bank0_acked", 32'(seen), 32'd1);
    rd[0] = 1'b0;
    rd[1] = 1'b1;
    @(negedge clk);
    rd[1] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack[1]) n_ack1++;
    end
    check("withdraw_no_ack", 32'(n_ack1), 32'd0);
    check_queues_empty("withdraw");

    // Reset asserted on the first dok cycle of a burst.
    a0 = 22'h000300;
    push_burst(2'd0, a0);
    rd[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (ack[0]) rd[0] = 1'b0;
      if (dok[0]) seen = 1'b1;
    end
    rd[0] = 1'b0;
    check("abort_first_dok_seen", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_dst", 32'(dst), 32'd0);
    check("abort_dok", 32'(dok), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_data", 32'(dr), 32'd0);
    check("abort_mem_rd", 32'(mrd), 32'd0);
    check("abort_mem_addr", 32'(maddr), 32'd0);
    #1 rst_n = 1'b1;
    n_stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (|dok || |rdy) n_stray++;
    end
    check("abort_no_stray", 32'(n_stray), 32'd0);
    run_vec(vecs[0]);
    check_queues_empty("after_abort");

    // BURST=1, LAT=1 instance: ack at t+1, dst/dok/rdy together at t+2.
    a3_1 = 22'h001234;
    rd1 = 4'b1000;
    @(negedge clk);
    check("b1_ack", 32'(ack1), 32'h8);
    check("b1_ack_cycle_dok", 32'(dok1), 32'd0);
    check("b1_mem_rd", 32'(mrd1), 32'd1);
    check("b1_mem_addr", 32'(maddr1), 32'hC01234);
    rd1 = 4'b0000;
    @(negedge clk);
    check("b1_dst", 32'(dst1), 32'h8);
    check("b1_dok", 32'(dok1), 32'h8);
    check("b1_rdy", 32'(rdy1), 32'h8);
    check("b1_data", 32'(dr1), 32'hD234);
    @(negedge clk);
    check("b1_after_strobes", {16'd0, ack1, dst1, dok1, rdy1}, 32'd0);
    check("b1_data_hold", 32'(dr1), 32'hD234);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
